// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_queue
// Brief    : Instruction fetch PC with a first-word-fall-through prefetch queue
//            and branch-redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic [31:0]              imem_a,
    input  logic [31:0]              imem_rd,
    input  logic                     br_taken,
    input  logic [31:0]              br_target,
    input  logic                     dec_ready,
    output logic                     instr_valid,
    output logic [31:0]              instr,
    output logic [31:0]              instr_pc,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int               c_aw    = $clog2(DEPTH);
    localparam int               c_cw    = c_aw + 1;
    localparam logic [c_cw-1:0]  c_depth = c_cw'(DEPTH);

    logic [31:0]      r_pc;
    logic [c_aw-1:0]  r_head;
    logic [c_aw-1:0]  r_tail;
    logic [c_cw-1:0]  r_count;
    logic [31:0]      r_mem_instr [DEPTH];
    logic [31:0]      r_mem_pc    [DEPTH];

    logic             w_valid;
    logic             w_pop;
    logic             w_push;

    assign w_valid = (r_count != '0) && !br_taken;
    assign w_pop   = w_valid && dec_ready;
    assign w_push  = !br_taken && ((r_count < c_depth) || w_pop);

    assign imem_a      = r_pc;
    assign instr_valid = w_valid;
    assign instr       = w_valid ? r_mem_instr[r_head] : 32'h0;
    assign instr_pc    = w_valid ? r_mem_pc[r_head]    : 32'h0;
    assign q_count     = r_count;

    // Control state; a redirect wins over everything and flushes the queue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc    <= RESET_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (br_taken) begin
            r_pc    <= br_target & 32'hFFFF_FFFC;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_pc   <= r_pc + 32'd4;
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage carries no reset; only the pointers qualify its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_tail] <= imem_rd;
            r_mem_pc[r_tail]    <= r_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_queue
// Brief    : Directed self-checking bench for ifetch_queue (memory word = address).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_queue;

    logic        clk;
    logic        reset_n;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic        br_taken;
    logic [31:0] br_target;
    logic        dec_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [2:0]  q_count;

    int n_tests = 0;
    int n_fail  = 0;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_a      (imem_a),
        .imem_rd     (imem_rd),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .dec_ready   (dec_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .q_count     (q_count)
    );

    assign imem_rd = imem_a;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'h0;
        dec_ready = 1'b0;
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'h0;
        dec_ready = 1'b1;

        // Reset held across an edge
        #7;
        check("rst_imem_a", imem_a, 32'h0);
        check("rst_count", 32'(q_count), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        #1;
        reset_n = 1'b1;

        // Streaming after reset release
        tick();
        check("s0_valid", 32'(instr_valid), 32'd1);
        check("s0_pc", instr_pc, 32'h0);
        check("s0_imem_a", imem_a, 32'h4);
        tick();
        check("s1_pc", instr_pc, 32'h4);
        check("s1_instr", instr, 32'h4);
        tick();
        check("s2_pc", instr_pc, 32'h8);
        check("s2_count", 32'(q_count), 32'd1);

        // Stall until full, then stream through a full queue
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        check("full_count", 32'(q_count), 32'd4);
        check("full_imem_a", imem_a, 32'h10);
        check("full_head", instr_pc, 32'h0);
        dec_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("stream_count", 32'(q_count), 32'd4);
            check("stream_pc", instr_pc, 32'(i * 4));
            check("stream_instr", instr, 32'(i * 4));
        end

        // Redirect with three queued entries
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        check("pre_br_count", 32'(q_count), 32'd3);
        br_taken  = 1'b1;
        br_target = 32'h0000_0103;
        #1;
        check("br_valid", 32'(instr_valid), 32'd0);
        check("br_instr", instr, 32'h0);
        tick();
        br_taken = 1'b0;
        #1;
        check("br_flush_count", 32'(q_count), 32'd0);
        check("br_imem_a", imem_a, 32'h100);
        check("br_empty_valid", 32'(instr_valid), 32'd0);
        tick();
        check("br_tgt_valid", 32'(instr_valid), 32'd1);
        check("br_tgt_pc", instr_pc, 32'h100);
        check("br_tgt_instr", instr, 32'h100);

        // Back-to-back redirects: last target wins, nothing pushed
        br_taken  = 1'b1;
        br_target = 32'h0000_0200;
        tick();
        br_target = 32'h0000_0302;
        tick();
        br_taken = 1'b0;
        #1;
        check("bb_imem_a", imem_a, 32'h300);
        check("bb_count", 32'(q_count), 32'd0);

        // Redirect near the top of the address space
        dec_ready = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'hFFFF_FFF8;
        tick();
        br_taken = 1'b0;
        tick();
        check("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
        tick();
        check("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc2", instr_pc, 32'h0000_0000);
        check("wrap_valid", 32'(instr_valid), 32'd1);

        // Asynchronous reset while full
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        check("pre_rst_count", 32'(q_count), 32'd4);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_count", 32'(q_count), 32'd0);
        check("arst_imem_a", imem_a, 32'h0);
        check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_instr", instr, 32'h0);
        check("arst_pc", instr_pc, 32'h0);
        reset_n = 1'b1;
        tick();
        check("post_rst_count", 32'(q_count), 32'd1);
        check("post_rst_pc", instr_pc, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
